// File: rtl/bpred_pkg.sv
// Shared definitions for the two-bit dynamic branch predictor: table geometry,
// counter state encoding and the saturating counter next-state function.
package bpred_pkg;

   localparam int IDX_W       = 4;
   localparam int NUM_ENTRIES = 16;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT      = 2'b00;
   localparam ctr_t WNT      = 2'b01;
   localparam ctr_t WT       = 2'b10;
   localparam ctr_t ST       = 2'b11;
   localparam ctr_t PHT_INIT = WNT;

   function automatic ctr_t pht_next(input ctr_t cur, input logic taken);
      ctr_t nxt;
      if (taken) nxt = (cur == ST)  ? ST  : cur + 2'd1;
      else       nxt = (cur == SNT) ? SNT : cur - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/decoder_four_sixteen.sv
// 4-to-16 one-hot decoder with enable; produces per-entry write enables.
module decoder_four_sixteen
   import bpred_pkg::*;
(
   input  logic                   en,
   input  logic [IDX_W-1:0]       idx,
   output logic [NUM_ENTRIES-1:0] onehot
);

   // Gating on en keeps a don't-care index from reaching table state.
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/bpred_pht16.sv
// Sixteen-entry PHT of 2-bit saturating counters with registered lookup and a
// saturating misprediction counter. Optional macro: BPRED_BYPASS_EN.
module bpred_pht16
   import bpred_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [3:0]       pred_idx,
   output logic             pred_out_valid,
   output logic             pred_taken,
   output logic [1:0]       pred_state,
   input  logic             upd_valid,
   input  logic [3:0]       upd_idx,
   input  logic             upd_taken,
   input  logic             upd_pred_taken,
   output logic [CNT_W-1:0] mispred_cnt
);

   ctr_t                   pht [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] upd_we;
   ctr_t                   upd_new;
   ctr_t                   look_val;
   logic                   mispred;

   decoder_four_sixteen u_dec (
      .en     (upd_valid),
      .idx    (upd_idx),
      .onehot (upd_we)
   );

   assign upd_new = pht_next(pht[upd_idx], upd_taken);
   assign mispred = upd_valid && (upd_taken != upd_pred_taken);

   always_comb begin
      look_val = pht[pred_idx];
`ifdef BPRED_BYPASS_EN
      // Write-through forward of a same-cycle update to the looked-up entry.
      if (upd_valid && (upd_idx == pred_idx)) look_val = upd_new;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) pht[i] <= PHT_INIT;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            if (upd_we[i]) pht[i] <= upd_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         pred_state     <= '0;
      end else begin
         pred_out_valid <= pred_valid;
         if (pred_valid) begin
            pred_state <= look_val;
            pred_taken <= look_val[1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                             mispred_cnt <= '0;
      else if (mispred && ~&mispred_cnt)   mispred_cnt <= mispred_cnt + 1'b1;
   end

endmodule

// File: tb/tb_bpred_pht16.sv
// Self-checking bench for bpred_pht16: directed scenarios plus randomized
// traffic against a behavioural counter-table model.
module tb_bpred_pht16;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid;
   logic [3:0]  pred_idx;
   logic        upd_valid;
   logic [3:0]  upd_idx;
   logic        upd_taken;
   logic        upd_pred_taken;

   logic        pov, ptk;
   logic [1:0]  pst;
   logic [15:0] cnt16;
   logic        pov4, ptk4;
   logic [1:0]  pst4;
   logic [3:0]  cnt4;

   int vectors = 0;
   int miscompares = 0;

`ifdef BPRED_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Reference model: counters as plain integers 0..3.
   int m_pht [16];
   int m_ps, m_pv, m_cnt16, m_cnt4;

   always #5 clk = ~clk;

   bpred_pht16 #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_idx(pred_idx),
      .pred_out_valid(pov), .pred_taken(ptk), .pred_state(pst),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_pred_taken(upd_pred_taken), .mispred_cnt(cnt16)
   );

   bpred_pht16 #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_idx(pred_idx),
      .pred_out_valid(pov4), .pred_taken(ptk4), .pred_state(pst4),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_pred_taken(upd_pred_taken), .mispred_cnt(cnt4)
   );

   // Drive one cycle's inputs, let one rising edge pass, sample 1 time unit after it.
   task automatic drive(input logic pv, input int pi, input logic uv, input int ui,
                        input logic ut, input logic upt, input logic r);
      int nxt;
      pred_valid = pv; pred_idx = 4'(pi);
      upd_valid = uv; upd_idx = 4'(ui); upd_taken = ut; upd_pred_taken = upt;
      rst = r;
      @(posedge clk); #1;
      if (r) begin
         for (int i = 0; i < 16; i++) m_pht[i] = 1;
         m_pv = 0; m_ps = 0; m_cnt16 = 0; m_cnt4 = 0;
      end else begin
         nxt = ut ? ((m_pht[ui] == 3) ? 3 : m_pht[ui] + 1)
                  : ((m_pht[ui] == 0) ? 0 : m_pht[ui] - 1);
         m_pv = pv;
         if (pv) m_ps = (BYP && uv && ui == pi) ? nxt : m_pht[pi];
         if (uv) begin
            m_pht[ui] = nxt;
            if (ut != upt) begin
               if (m_cnt16 < 65535) m_cnt16++;
               if (m_cnt4 < 15) m_cnt4++;
            end
         end
      end
      pred_valid = 1'b0; upd_valid = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset;
      drive(0, 0, 0, 0, 0, 0, 1);
      vectors++;
      if ({pov, ptk, pst} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 0000", {pov, ptk, pst});
      end
      vectors++;
      if (cnt16 !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_cnt: got %0d expected 0", cnt16);
      end
      for (int i = 0; i < 16; i++) begin
         drive(1, i, 0, 0, 0, 0, 0);
         vectors++;
         if ({pov, ptk, pst} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_lookup[%0d]: got v/t/s=%b expected 1001", i, {pov, ptk, pst});
         end
      end
   endtask

   task automatic test_saturate_up;
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) drive(0, 0, 1, 5, 1, 1, 0);
      drive(1, 5, 0, 0, 0, 0, 0);
      vectors++;
      if ({ptk, pst} !== 3'b111) begin
         miscompares++;
         $display("FAIL up3_e5: got t/s=%b expected 111", {ptk, pst});
      end
      drive(0, 0, 1, 5, 1, 1, 0);
      drive(1, 5, 0, 0, 0, 0, 0);
      vectors++;
      if (pst !== 2'b11) begin
         miscompares++;
         $display("FAIL up4_e5: got %b expected 11", pst);
      end
      // Lookup idle: valid drops, prediction holds even with a different index.
      drive(0, 4, 0, 0, 0, 0, 0);
      vectors++;
      if ({pov, ptk, pst} !== 4'b0111) begin
         miscompares++;
         $display("FAIL hold: got v/t/s=%b expected 0111", {pov, ptk, pst});
      end
      for (int i = 4; i <= 6; i += 2) begin
         drive(1, i, 0, 0, 0, 0, 0);
         vectors++;
         if (pst !== 2'b01) begin
            miscompares++;
            $display("FAIL neighbour_e%0d: got %b expected 01", i, pst);
         end
      end
   endtask

   task automatic test_saturate_down;
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) drive(0, 0, 1, 9, 0, 0, 0);
      drive(1, 9, 0, 0, 0, 0, 0);
      vectors++;
      if ({ptk, pst} !== 3'b000) begin
         miscompares++;
         $display("FAIL down2_e9: got t/s=%b expected 000", {ptk, pst});
      end
      for (int k = 0; k < 2; k++) drive(0, 0, 1, 9, 1, 1, 0);
      drive(1, 9, 0, 0, 0, 0, 0);
      vectors++;
      if ({ptk, pst} !== 3'b110) begin
         miscompares++;
         $display("FAIL up2_e9: got t/s=%b expected 110", {ptk, pst});
      end
   endtask

   task automatic test_same_cycle;
      logic [1:0] exp_s;
      exp_s = BYP ? 2'b10 : 2'b01;
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(1, 3, 1, 3, 1, 1, 0);
      vectors++;
      if (pst !== exp_s) begin
         miscompares++;
         $display("FAIL same_cycle_e3: got %b expected %b", pst, exp_s);
      end
      drive(1, 3, 0, 0, 0, 0, 0);
      vectors++;
      if (pst !== 2'b10) begin
         miscompares++;
         $display("FAIL next_cycle_e3: got %b expected 10", pst);
      end
   endtask

   task automatic test_mispred;
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
         if (k % 3 == 1) drive(0, 0, 1, k, 1, 1, 0);
         else            drive(0, 0, 1, k, k[0], ~k[0], 0);
      end
      vectors++;
      if (cnt16 !== 16'd5) begin
         miscompares++;
         $display("FAIL mispred_5: got %0d expected 5", cnt16);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 20; k++) drive(0, 0, 1, k % 16, 1, 0, 0);
      vectors++;
      if (cnt4 !== 4'd15) begin
         miscompares++;
         $display("FAIL mispred_sat4: got %0d expected 15", cnt4);
      end
      vectors++;
      if (cnt16 !== 16'd20) begin
         miscompares++;
         $display("FAIL mispred_20: got %0d expected 20", cnt16);
      end
   endtask

   task automatic test_reset_collision;
      drive(0, 0, 1, 7, 1, 0, 0);
      drive(1, 7, 1, 7, 1, 0, 1);
      vectors++;
      if ({pov, ptk, pst} !== 4'b0000 || cnt16 !== 16'd0) begin
         miscompares++;
         $display("FAIL rst_collide_out: got v/t/s=%b cnt=%0d expected 0000 cnt=0",
                  {pov, ptk, pst}, cnt16);
      end
      drive(1, 7, 0, 0, 0, 0, 0);
      vectors++;
      if ({pov, pst} !== 3'b101) begin
         miscompares++;
         $display("FAIL rst_collide_e7: got v/s=%b expected 101", {pov, pst});
      end
   endtask

   task automatic test_random;
      int pi, ui;
      logic r;
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 600; n++) begin
         pi = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         ui = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         r  = ($urandom_range(0, 59) == 0);
         drive(1'($urandom), pi, 1'($urandom), ui, 1'($urandom), 1'($urandom), r);
         vectors++;
         if (pov !== 1'(m_pv) || pst !== 2'(m_ps) || ptk !== (m_ps >= 2)) begin
            miscompares++;
            $display("FAIL rand_pred[%0d]: got v/t/s=%b%b%b expected %0d/%0d/%0d",
                     n, pov, ptk, pst, m_pv, m_ps >= 2, m_ps);
         end
         vectors++;
         if (cnt16 !== 16'(m_cnt16) || cnt4 !== 4'(m_cnt4) || pst4 !== 2'(m_ps)) begin
            miscompares++;
            $display("FAIL rand_cnt[%0d]: got %0d/%0d/s4=%0d expected %0d/%0d/%0d",
                     n, cnt16, cnt4, pst4, m_cnt16, m_cnt4, m_ps);
         end
      end
   endtask

   initial begin
      rst = 1'b1; pred_valid = 1'b0; pred_idx = '0; upd_valid = 1'b0;
      upd_idx = '0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
      test_reset();
      test_saturate_up();
      test_saturate_down();
      test_same_cycle();
      test_mispred();
      test_reset_collision();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
